// File: rtl/cpu_step_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_step_ctrl_if
// Description : Bundles the board-side inputs (button, mode switch), the
//               breakpoint/PC inputs and the CPU-facing enable and status
//               outputs of the execution-control stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_step_ctrl_if;
    logic        btn;
    logic        run_sw;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic        cpu_ce;
    logic [15:0] step_count;
    logic        running;
    logic        halted;
    logic        btn_db;

    // Controller side: consumes the board/CPU inputs, produces the enable and status.
    modport slave (
        input  btn, run_sw, bp_en, bp_addr, pc,
        output cpu_ce, step_count, running, halted, btn_db
    );

    // Environment side: drives the board/CPU inputs, observes the enable and status.
    modport master (
        output btn, run_sw, bp_en, bp_addr, pc,
        input  cpu_ce, step_count, running, halted, btn_db
    );
endinterface
`default_nettype wire

// File: rtl/cpu_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_step_ctrl
// Description : Execution control for the single-cycle core. Conditions the
//               push-button and run/step switch, then issues one-cycle clock
//               enables: one per press in STEP, one per RUN_DIV cycles in RUN,
//               halting in BREAK when the PC matches the breakpoint address.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int RUN_DIV         = 10_000_000
) (
    input  wire logic       clk100MHZ,
    input  wire logic       rst_n,
    cpu_step_ctrl_if.slave  ctrl
);

    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RUN_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        ST_STEP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BREAK = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             btn_meta_q, btn_sync_q;
    logic             run_meta_q, run_sync_q;
    logic [DB_W-1:0]  db_cnt_q;
    logic             btn_db_q, btn_db_prev_q;
    logic [RUN_W-1:0] run_cnt_q;
    logic             tick_q;
    logic             cpu_ce_q, cpu_ce_d;
    logic             running_q, halted_q;
    logic [15:0]      step_count_q;
    logic             press;
    logic             pulse;

    // Two-flop synchronizers for the asynchronous button and mode switch.
    always_ff @(posedge clk100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            run_meta_q <= 1'b0;
            run_sync_q <= 1'b0;
        end else begin
            btn_meta_q <= ctrl.btn;
            btn_sync_q <= btn_meta_q;
            run_meta_q <= ctrl.run_sw;
            run_sync_q <= run_meta_q;
        end
    end

    // Debounce: the level only flips after DEBOUNCE_CYCLES of continuous disagreement.
    always_ff @(posedge clk100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q      <= '0;
            btn_db_q      <= 1'b0;
            btn_db_prev_q <= 1'b0;
        end else begin
            btn_db_prev_q <= btn_db_q;
            if (btn_sync_q == btn_db_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
                btn_db_q <= ~btn_db_q;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end
    end

    assign press = btn_db_q & ~btn_db_prev_q;

    // Rate divider: held at zero outside RUN so every entry to RUN starts a full period.
    always_ff @(posedge clk100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else if (state_q != ST_RUN) begin
            run_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            tick_q    <= (run_cnt_q == RUN_LAST);
            run_cnt_q <= (run_cnt_q == RUN_LAST) ? '0 : run_cnt_q + 1'b1;
        end
    end

    // Next-state and enable decode; a mode change always beats a press or tick.
    always_comb begin
        state_d = state_q;
        pulse   = 1'b0;
        case (state_q)
            ST_STEP: begin
                if (run_sync_q) begin
                    state_d = ST_RUN;
                end else if (press) begin
                    pulse = 1'b1;
                end
            end
            ST_RUN: begin
                if (!run_sync_q) begin
                    state_d = ST_STEP;
                end else if (tick_q) begin
                    if (ctrl.bp_en && (ctrl.pc == ctrl.bp_addr)) begin
                        state_d = ST_BREAK;
                    end else begin
                        pulse = 1'b1;
                    end
                end
            end
            ST_BREAK: begin
                if (!run_sync_q) begin
                    state_d = ST_STEP;
                end else if (press) begin
                    pulse   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_STEP;
        endcase
        // Guarantees a gap between enables even with a degenerate RUN_DIV.
        cpu_ce_d = pulse & ~cpu_ce_q;
    end

    // State register with registered enable and status flags.
    always_ff @(posedge clk100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_STEP;
            cpu_ce_q  <= 1'b0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cpu_ce_q  <= cpu_ce_d;
            running_q <= (state_d == ST_RUN);
            halted_q  <= (state_d == ST_BREAK);
        end
    end

    // Retired-step counter, advanced on the same edge that raises cpu_ce.
    always_ff @(posedge clk100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            step_count_q <= 16'd0;
        end else if (cpu_ce_d) begin
            step_count_q <= step_count_q + 16'd1;
        end
    end

    assign ctrl.cpu_ce     = cpu_ce_q;
    assign ctrl.step_count = step_count_q;
    assign ctrl.running    = running_q;
    assign ctrl.halted     = halted_q;
    assign ctrl.btn_db     = btn_db_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_step_ctrl
// Description : Directed bench for cpu_step_ctrl with DEBOUNCE_CYCLES=4 and
//               RUN_DIV=5; expected cycle positions are hand-derived.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_step_ctrl;

    localparam int DB = 4;
    localparam int RD = 5;

    logic clk100MHZ = 1'b0;
    logic rst_n     = 1'b0;
    int   n_checks  = 0;
    int   n_pass    = 0;

    cpu_step_ctrl_if bus();

    cpu_step_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .RUN_DIV        (RD)
    ) dut (
        .clk100MHZ(clk100MHZ),
        .rst_n    (rst_n),
        .ctrl     (bus.slave)
    );

    always #5 clk100MHZ = ~clk100MHZ;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk100MHZ);
        #1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.btn      = 1'b0;
        bus.run_sw   = 1'b0;
        bus.bp_en    = 1'b0;
        bus.bp_addr  = 32'h0;
        bus.pc       = 32'h0;
        repeat (3) step();
        n_checks++; if (bus.cpu_ce !== 1'b0) $display("FAIL reset_cpu_ce got=%b exp=0", bus.cpu_ce); else n_pass++;
        n_checks++; if (bus.step_count !== 16'h0) $display("FAIL reset_step_count got=%h exp=0000", bus.step_count); else n_pass++;
        n_checks++; if (bus.running !== 1'b0) $display("FAIL reset_running got=%b exp=0", bus.running); else n_pass++;
        n_checks++; if (bus.halted !== 1'b0) $display("FAIL reset_halted got=%b exp=0", bus.halted); else n_pass++;
        n_checks++; if (bus.btn_db !== 1'b0) $display("FAIL reset_btn_db got=%b exp=0", bus.btn_db); else n_pass++;
        rst_n = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_step();
        int   rise_k  = -1;
        int   first_k = -1;
        int   nce     = 0;
        logic prev_db;
        prev_db = bus.btn_db;
        bus.btn = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            step();
            if (bus.btn_db && !prev_db && rise_k < 0) rise_k = k;
            prev_db = bus.btn_db;
            if (bus.cpu_ce) begin
                nce++;
                if (first_k < 0) first_k = k;
            end
            if (k == 10) bus.btn = 1'b0;
        end
        n_checks++; if (rise_k != 6) $display("FAIL step_db_rise got=%0d exp=6", rise_k); else n_pass++;
        n_checks++; if (first_k != 7) $display("FAIL step_ce_cycle got=%0d exp=7", first_k); else n_pass++;
        n_checks++; if (nce != 1) $display("FAIL step_ce_count got=%0d exp=1", nce); else n_pass++;
        n_checks++; if (bus.step_count !== 16'd1) $display("FAIL step_count got=%h exp=0001", bus.step_count); else n_pass++;
        n_checks++; if (bus.btn_db !== 1'b0) $display("FAIL step_db_release got=%b exp=0", bus.btn_db); else n_pass++;
    endtask

    task automatic test_bounce();
        int nce     = 0;
        int db_seen = 0;
        for (int k = 0; k < 28; k++) begin
            bus.btn = (k < 20) ? (((k / 2) % 2) == 0) : 1'b0;
            step();
            if (bus.btn_db) db_seen++;
            if (bus.cpu_ce) nce++;
        end
        n_checks++; if (db_seen != 0) $display("FAIL bounce_db got=%0d high cycles exp=0", db_seen); else n_pass++;
        n_checks++; if (nce != 0) $display("FAIL bounce_ce got=%0d pulses exp=0", nce); else n_pass++;
        n_checks++; if (bus.step_count !== 16'd1) $display("FAIL bounce_count got=%h exp=0001", bus.step_count); else n_pass++;
    endtask

    task automatic test_free_run();
        int pk[$];
        int gap_bad = 0;
        bus.run_sw = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            step();
            if (k == 2) begin
                n_checks++; if (bus.running !== 1'b0) $display("FAIL run_entry_early got=%b exp=0", bus.running); else n_pass++;
            end
            if (k == 3) begin
                n_checks++; if (bus.running !== 1'b1) $display("FAIL run_entry got=%b exp=1", bus.running); else n_pass++;
            end
            if (bus.cpu_ce) pk.push_back(k);
            if (k == 60) bus.run_sw = 1'b0;
        end
        for (int i = 1; i < pk.size(); i++) if (pk[i] - pk[i-1] != RD) gap_bad++;
        n_checks++; if (pk.size() != 11) $display("FAIL run_pulse_count got=%0d exp=11", pk.size()); else n_pass++;
        n_checks++; if (pk.size() == 0 || pk[0] != 9) $display("FAIL run_first_pulse got=%0d exp=9", (pk.size() == 0) ? -1 : pk[0]); else n_pass++;
        n_checks++; if (gap_bad != 0) $display("FAIL run_spacing got=%0d bad gaps exp=0", gap_bad); else n_pass++;
        n_checks++; if (bus.step_count !== 16'd12) $display("FAIL run_count got=%h exp=000c", bus.step_count); else n_pass++;
        n_checks++; if (bus.running !== 1'b0) $display("FAIL run_exit got=%b exp=0", bus.running); else n_pass++;
    endtask

    task automatic test_breakpoint();
        int pk[$];
        int pk2[$];
        bus.bp_en   = 1'b1;
        bus.bp_addr = 32'h0000_000C;
        bus.pc      = 32'h0;
        bus.run_sw  = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            step();
            if (bus.cpu_ce) pk.push_back(k);
            if (k == 14) bus.pc = 32'h0000_000C;
            if (k == 18) begin
                n_checks++; if (bus.halted !== 1'b0) $display("FAIL bp_early got=%b exp=0", bus.halted); else n_pass++;
            end
            if (k == 19) begin
                n_checks++; if (bus.halted !== 1'b1) $display("FAIL bp_halted got=%b exp=1", bus.halted); else n_pass++;
                n_checks++; if (bus.running !== 1'b0) $display("FAIL bp_running got=%b exp=0", bus.running); else n_pass++;
            end
        end
        n_checks++; if (pk.size() != 2 || pk[0] != 9 || pk[1] != 14) $display("FAIL bp_pulses got=%0d pulses exp=2 at 9,14", pk.size()); else n_pass++;
        n_checks++; if (bus.step_count !== 16'd14) $display("FAIL bp_count got=%h exp=000e", bus.step_count); else n_pass++;
        // Press resumes: one pulse, then RUN with a fresh period.
        bus.btn = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (bus.cpu_ce) pk2.push_back(k);
            if (k == 7) begin
                n_checks++; if (bus.running !== 1'b1) $display("FAIL bp_resume_running got=%b exp=1", bus.running); else n_pass++;
                n_checks++; if (bus.halted !== 1'b0) $display("FAIL bp_resume_halted got=%b exp=0", bus.halted); else n_pass++;
                bus.pc = 32'h0000_0010;
            end
            if (k == 10) bus.btn = 1'b0;
            if (k == 14) bus.pc = 32'h0000_000C;
        end
        n_checks++; if (pk2.size() != 2 || pk2[0] != 7 || pk2[1] != 13) $display("FAIL bp_resume_pulses got=%0d pulses exp=2 at 7,13", pk2.size()); else n_pass++;
        n_checks++; if (bus.halted !== 1'b1) $display("FAIL bp_rehalt got=%b exp=1", bus.halted); else n_pass++;
        n_checks++; if (bus.step_count !== 16'd16) $display("FAIL bp_resume_count got=%h exp=0010", bus.step_count); else n_pass++;
    endtask

    task automatic test_mode_race();
        int nce = 0;
        bus.btn = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (bus.cpu_ce) nce++;
            if (k == 4) bus.run_sw = 1'b0;
            if (k == 6) begin
                n_checks++; if (bus.halted !== 1'b1) $display("FAIL race_pre_halted got=%b exp=1", bus.halted); else n_pass++;
            end
            if (k == 7) begin
                n_checks++; if (bus.halted !== 1'b0) $display("FAIL race_halted got=%b exp=0", bus.halted); else n_pass++;
                n_checks++; if (bus.running !== 1'b0) $display("FAIL race_running got=%b exp=0", bus.running); else n_pass++;
            end
            if (k == 10) bus.btn = 1'b0;
        end
        n_checks++; if (nce != 0) $display("FAIL race_ce got=%0d pulses exp=0", nce); else n_pass++;
        n_checks++; if (bus.step_count !== 16'd16) $display("FAIL race_count got=%h exp=0010", bus.step_count); else n_pass++;
    endtask

    task automatic test_wrap_reset();
        bus.bp_en = 1'b0;
        bus.pc    = 32'h0;
        repeat (3) step();
        force dut.step_count_q = 16'hFFFE;
        step();
        release dut.step_count_q;
        bus.run_sw = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            step();
            if (k == 9) begin
                n_checks++; if (bus.step_count !== 16'hFFFF) $display("FAIL wrap_ffff got=%h exp=ffff", bus.step_count); else n_pass++;
            end
            if (k == 14) begin
                n_checks++; if (bus.step_count !== 16'h0000) $display("FAIL wrap_zero got=%h exp=0000", bus.step_count); else n_pass++;
            end
            if (k == 19) begin
                n_checks++; if (bus.cpu_ce !== 1'b1) $display("FAIL wrap_pre_ce got=%b exp=1", bus.cpu_ce); else n_pass++;
                n_checks++; if (bus.step_count !== 16'h0001) $display("FAIL wrap_one got=%h exp=0001", bus.step_count); else n_pass++;
            end
        end
        // Asynchronous reset between edges while a pulse is high in RUN.
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.cpu_ce !== 1'b0) $display("FAIL areset_cpu_ce got=%b exp=0", bus.cpu_ce); else n_pass++;
        n_checks++; if (bus.step_count !== 16'h0) $display("FAIL areset_count got=%h exp=0000", bus.step_count); else n_pass++;
        n_checks++; if (bus.running !== 1'b0) $display("FAIL areset_running got=%b exp=0", bus.running); else n_pass++;
        n_checks++; if (bus.halted !== 1'b0) $display("FAIL areset_halted got=%b exp=0", bus.halted); else n_pass++;
        n_checks++; if (bus.btn_db !== 1'b0) $display("FAIL areset_btn_db got=%b exp=0", bus.btn_db); else n_pass++;
        bus.run_sw = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();
    endtask

    initial begin
        test_reset();
        test_step();
        test_bounce();
        test_free_run();
        test_breakpoint();
        test_mode_race();
        test_wrap_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
